// File: rtl/cuenta1_seq.sv
// cuenta1_seq: feeds 3-bit words to the cuenta1 one-counter one at a time.
// It launches each word with a single Start pulse and waits for the counter's
// Fin low-then-high sequence. The captured Cuenta is returned over a
// valid/ready port, and saturating totals are kept. A wait-state timeout
// aborts a word if the counter never answers.
module cuenta1_seq #(
    parameter int TIMEOUT = 64,
    parameter int TOT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       dato_in,
    input  logic             dato_valid,
    output logic             dato_ready,
    output logic [2:0]       Q,
    output logic             Start,
    input  logic [3:0]       Cuenta,
    input  logic             Fin,
    output logic [3:0]       res_cuenta,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TOT_W-1:0] total,
    output logic [TOT_W-1:0] n_words,
    output logic             err
);

    localparam int                TMO_W     = $clog2(TIMEOUT + 1);
    localparam int                SUM_W     = TOT_W + 1;
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT);
    localparam logic [TOT_W-1:0]  SAT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_FIN,
        S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         q_q, q_d;
    logic               start_q, start_d;
    logic               dato_ready_q, dato_ready_d;
    logic [3:0]         res_cuenta_q, res_cuenta_d;
    logic               res_valid_q, res_valid_d;
    logic [TOT_W-1:0]   total_q, total_d;
    logic [TOT_W-1:0]   n_words_q, n_words_d;
    logic               err_q, err_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic               accept;
    logic [TMO_W-1:0]   tmo_inc;
    logic [SUM_W-1:0]   sum_ext;
    logic [SUM_W-1:0]   cnt_ext;

    // Next-state and next-output computation for the word sequencer.
    always_comb begin
        state_d      = state_q;
        q_d          = q_q;
        res_cuenta_d = res_cuenta_q;
        res_valid_d  = res_valid_q;
        total_d      = total_q;
        n_words_d    = n_words_q;
        err_d        = err_q;
        tmo_d        = tmo_q;

        accept  = dato_valid & dato_ready_q;
        tmo_inc = tmo_q + TMO_W'(1);
        // Sums carry one extra bit so an overflow is visible and can be clamped.
        sum_ext = {1'b0, total_q} + SUM_W'(res_cuenta_q);
        cnt_ext = {1'b0, n_words_q} + SUM_W'(1);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    q_d     = dato_in;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tmo_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // Fin high here is only the counter's idle level, not completion.
                tmo_d = tmo_inc;
                if (tmo_inc == TMO_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (!Fin) begin
                    state_d = S_WAIT_FIN;
                end
            end
            S_WAIT_FIN: begin
                tmo_d = tmo_inc;
                if (tmo_inc == TMO_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (Fin) begin
                    res_cuenta_d = Cuenta;
                    res_valid_d  = 1'b1;
                    state_d      = S_OUT;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    total_d     = sum_ext[TOT_W] ? SAT_MAX : sum_ext[TOT_W-1:0];
                    n_words_d   = cnt_ext[TOT_W] ? SAT_MAX : cnt_ext[TOT_W-1:0];
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Start and dato_ready are registered images of the state being entered.
        start_d      = (state_d == S_LAUNCH);
        dato_ready_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            q_q          <= '0;
            start_q      <= 1'b0;
            dato_ready_q <= 1'b0;
            res_cuenta_q <= '0;
            res_valid_q  <= 1'b0;
            total_q      <= '0;
            n_words_q    <= '0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            q_q          <= q_d;
            start_q      <= start_d;
            dato_ready_q <= dato_ready_d;
            res_cuenta_q <= res_cuenta_d;
            res_valid_q  <= res_valid_d;
            total_q      <= total_d;
            n_words_q    <= n_words_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign dato_ready = dato_ready_q;
    assign Q          = q_q;
    assign Start      = start_q;
    assign res_cuenta = res_cuenta_q;
    assign res_valid  = res_valid_q;
    assign total      = total_q;
    assign n_words    = n_words_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cuenta1_seq.sv
// Testbench for cuenta1_seq: the bench drives Fin/Cuenta itself as a cuenta1
// stand-in, and a saturating-sum reference model tracks total and n_words.
module tb_cuenta1_seq;

    localparam int TOT_W   = 8;
    localparam int TIMEOUT = 64;
    localparam int MAXV    = (1 << TOT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       dato_in;
    logic             dato_valid;
    logic             dato_ready;
    logic [2:0]       Q;
    logic             Start;
    logic [3:0]       Cuenta;
    logic             Fin;
    logic [3:0]       res_cuenta;
    logic             res_valid;
    logic             res_ready;
    logic [TOT_W-1:0] total;
    logic [TOT_W-1:0] n_words;
    logic             err;

    cuenta1_seq #(.TIMEOUT(TIMEOUT), .TOT_W(TOT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dato_in    (dato_in),
        .dato_valid (dato_valid),
        .dato_ready (dato_ready),
        .Q          (Q),
        .Start      (Start),
        .Cuenta     (Cuenta),
        .Fin        (Fin),
        .res_cuenta (res_cuenta),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .total      (total),
        .n_words    (n_words),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int mdl_total = 0;
    int mdl_n = 0;
    int mdl_err = 0;
    int launched = 0;
    int start_seen = 0;
    int word_no = 0;

    typedef struct {
        logic [2:0] w;
        int         pre;
        int         lo;
        logic [3:0] cnt;
        int         bp;
        int         exp_total;
        int         exp_n;
    } vec_t;

    vec_t tbl[6];

    // Independent count of every cycle Start is seen high.
    always @(negedge clk) begin
        if (Start === 1'b1) start_seen++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > MAXV) ? MAXV : a + b;
    endfunction

    task automatic all_zero(input string name);
        chk({name, "_Q"}, Q, 0);
        chk({name, "_Start"}, Start, 0);
        chk({name, "_ready"}, dato_ready, 0);
        chk({name, "_res"}, {res_cuenta, res_valid}, 0);
        chk({name, "_totals"}, {total, n_words}, 0);
        chk({name, "_err"}, err, 0);
    endtask

    task automatic clear_model();
        mdl_total = 0;
        mdl_n     = 0;
        mdl_err   = 0;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (dato_ready !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        chk("ready_before_word", dato_ready, 1);
    endtask

    // Accept a word; on return the DUT is in its launch cycle.
    task automatic launch(input logic [2:0] w);
        wait_ready();
        dato_in    = w;
        dato_valid = 1'b1;
        tick();
        launched++;
        dato_valid = 1'b0;
        chk("start_in_launch", Start, 1);
        chk("q_in_launch", Q, w);
        chk("ready_in_launch", dato_ready, 0);
    endtask

    // Full word: pre cycles of Fin high while waiting for busy, lo cycles of
    // Fin low, then Fin high with cnt, then bp cycles of back-pressure.
    task automatic run_word(input logic [2:0] w, input int pre, input int lo,
                            input logic [3:0] cnt, input int bp, input bit noise);
        launch(w);
        Fin = 1'b1;
        tick();
        chk("start_single", Start, 0);
        for (int i = 0; i < pre; i++) begin
            Fin    = 1'b1;
            Cuenta = 4'($urandom);
            if (noise) begin
                dato_valid = 1'($urandom);
                dato_in    = 3'($urandom);
            end
            tick();
        end
        Fin = 1'b0;
        tick();
        for (int i = 1; i < lo; i++) begin
            Cuenta = 4'($urandom);
            if (noise) begin
                dato_valid = 1'($urandom);
                dato_in    = 3'($urandom);
            end
            tick();
        end
        chk("no_result_while_busy", res_valid, 0);
        Fin    = 1'b1;
        Cuenta = cnt;
        tick();
        Cuenta = 4'($urandom);
        chk("res_valid_set", res_valid, 1);
        chk("res_cuenta", res_cuenta, cnt);
        for (int i = 0; i < bp; i++) begin
            res_ready = 1'b0;
            if (noise) begin
                dato_valid = 1'($urandom);
                dato_in    = 3'($urandom);
            end
            tick();
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_cuenta", res_cuenta, cnt);
            chk("bp_ready_low", dato_ready, 0);
            chk("bp_total_held", total, mdl_total);
            chk("bp_q_held", Q, w);
        end
        dato_valid = 1'b0;
        res_ready  = 1'b1;
        tick();
        res_ready = 1'b0;
        mdl_total = sat_add(mdl_total, int'(cnt));
        mdl_n     = sat_add(mdl_n, 1);
        chk("res_valid_clear", res_valid, 0);
        chk("total", total, mdl_total);
        chk("n_words", n_words, mdl_n);
        chk("ready_after", dato_ready, 1);
        chk("q_after", Q, w);
        chk("err_state", err, mdl_err);
        word_no++;
        $display("word %0d: Q=%0d cuenta=%0d total=%0d n_words=%0d err=%0d",
                 word_no, Q, res_cuenta, total, n_words, err);
    endtask

    initial begin
        int any_valid;

        tbl[0] = '{w: 3'b111, pre: 0, lo: 2, cnt: 4'd3,  bp: 0, exp_total: 3,  exp_n: 1};
        tbl[1] = '{w: 3'b101, pre: 2, lo: 1, cnt: 4'd2,  bp: 5, exp_total: 5,  exp_n: 2};
        tbl[2] = '{w: 3'b000, pre: 0, lo: 1, cnt: 4'd0,  bp: 1, exp_total: 5,  exp_n: 3};
        tbl[3] = '{w: 3'b011, pre: 5, lo: 4, cnt: 4'd15, bp: 2, exp_total: 20, exp_n: 4};
        tbl[4] = '{w: 3'b110, pre: 1, lo: 1, cnt: 4'd9,  bp: 0, exp_total: 29, exp_n: 5};
        tbl[5] = '{w: 3'b001, pre: 0, lo: 3, cnt: 4'd1,  bp: 3, exp_total: 30, exp_n: 6};

        rst_n      = 1'b0;
        dato_in    = '0;
        dato_valid = 1'b0;
        Cuenta     = '0;
        Fin        = 1'b1;
        res_ready  = 1'b0;

        // Reset held for three cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            dato_in    = 3'($urandom);
            dato_valid = 1'($urandom);
            Cuenta     = 4'($urandom);
            Fin        = 1'($urandom);
            res_ready  = 1'($urandom);
            tick();
            all_zero("reset");
        end
        dato_valid = 1'b0;
        res_ready  = 1'b0;
        Fin        = 1'b1;
        rst_n      = 1'b1;
        tick();
        chk("ready_after_release", dato_ready, 1);
        chk("err_after_release", err, 0);
        clear_model();

        // Directed table of words.
        for (int i = 0; i < 6; i++) begin
            run_word(tbl[i].w, tbl[i].pre, tbl[i].lo, tbl[i].cnt, tbl[i].bp, 1'b0);
            chk("tbl_total", total, tbl[i].exp_total);
            chk("tbl_n_words", n_words, tbl[i].exp_n);
        end

        // Timeout: Fin never drops, so the word is abandoned after the wait budget.
        launch(3'b010);
        Fin = 1'b1;
        any_valid = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            if (res_valid !== 1'b0) any_valid = 1;
        end
        chk("err_not_early", err, 0);
        chk("ready_not_early", dato_ready, 0);
        tick();
        if (res_valid !== 1'b0) any_valid = 1;
        mdl_err = 1;
        chk("timeout_err", err, 1);
        chk("timeout_idle", dato_ready, 1);
        chk("timeout_no_result", any_valid, 0);
        chk("timeout_total", total, mdl_total);
        chk("timeout_n_words", n_words, mdl_n);
        $display("timeout: err=%0d total=%0d n_words=%0d", err, total, n_words);
        run_word(3'b100, 0, 1, 4'd1, 0, 1'b0);

        // Reset while waiting for Fin high.
        launch(3'b111);
        Fin = 1'b1;
        tick();
        Fin = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        all_zero("reset_wait_fin");
        clear_model();
        Fin   = 1'b1;
        rst_n = 1'b1;
        tick();
        chk("ready_after_mid_reset", dato_ready, 1);
        run_word(3'b011, 0, 1, 4'd2, 1, 1'b0);

        // Reset while a result is pending.
        launch(3'b101);
        Fin = 1'b1;
        tick();
        Fin = 1'b0;
        tick();
        Fin    = 1'b1;
        Cuenta = 4'd7;
        tick();
        chk("pending_before_reset", res_valid, 1);
        rst_n = 1'b0;
        tick();
        all_zero("reset_out");
        clear_model();
        rst_n = 1'b1;
        tick();

        // Random words with noisy inputs against the saturating model.
        for (int i = 0; i < 40; i++) begin
            run_word(3'($urandom), $urandom_range(0, 6), $urandom_range(1, 6),
                     4'($urandom), $urandom_range(0, 4), 1'b1);
        end

        // Saturation: 100 words of 3 clamp at the top of the range.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        clear_model();
        for (int i = 0; i < 100; i++) begin
            run_word(3'b111, 0, 1, 4'd3, 0, 1'b0);
        end
        chk("sat_total", total, MAXV);
        chk("sat_n_words", n_words, 100);

        tick();
        chk("start_pulses", start_seen, launched);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global bound so a stuck handshake still reaches a verdict.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/cuenta1_seq.md
Name: cuenta1_seq

Overview:
- Sequencer that sits directly upstream of the `cuenta1` one-counter.
- Accepts 3-bit words over a valid/ready handshake and presents each word on `Q` with a one-cycle `Start` pulse.
- Waits for the counter's `Fin` completion, captures `Cuenta`, returns the result over a valid/ready output, and keeps a saturating running total.
- Includes a timeout so a stuck counter cannot hang the pipeline.

Parameters:
- TIMEOUT, 64, max cycles spent in WAIT_BUSY + WAIT_FIN before aborting a word.
- TOT_W, 8, width of the running-total and word-count registers.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- dato_in  in  3  word to count.
- dato_valid  in  1  dato_in is valid.
- dato_ready  out  1  block can accept a word.
- Q  out  3  word driven to cuenta1.
- Start  out  1  one-cycle launch pulse to cuenta1.
- Cuenta  in  4  count result from cuenta1.
- Fin  in  1  cuenta1 done flag (low while busy, high when done/idle).
- res_cuenta  out  4  captured count.
- res_valid  out  1  res_cuenta valid.
- res_ready  in  1  downstream accepts the result.
- total  out  TOT_W  saturating sum of all delivered res_cuenta.
- n_words  out  TOT_W  saturating count of delivered results.
- err  out  1  sticky timeout flag.

Behaviour:
- One clock domain. Reset is synchronous, active-low, sampled on the clk rising edge.
- Reset values: state=IDLE, Q=0, Start=0, dato_ready=0, res_cuenta=0, res_valid=0, total=0, n_words=0, err=0, timeout counter=0.
- dato_ready=1 only in IDLE and not in reset. A word is accepted on a cycle with dato_valid & dato_ready.
- States and transitions:
  - IDLE: on accept, register dato_in into Q and go to LAUNCH. Otherwise stay.
  - LAUNCH (exactly 1 cycle): Start=1, Q held. Go to WAIT_BUSY. The timeout counter clears here.
  - WAIT_BUSY: wait for Fin==0, which confirms cuenta1 took the start. On Fin==0 go to WAIT_FIN.
  - WAIT_FIN: on Fin==1, register res_cuenta=Cuenta, set res_valid=1, go to OUT.
  - OUT: hold res_cuenta and res_valid until res_ready. On the handshake cycle:
    - clear res_valid;
    - total <= min(total+res_cuenta, 2^TOT_W-1);
    - n_words <= min(n_words+1, 2^TOT_W-1);
    - go to IDLE.
- Start is high only in LAUNCH and is never asserted twice per word.
- Q stays stable from LAUNCH until the next accept. It is not changed in OUT or IDLE.
- Latency:
  - accept at cycle t;
  - Start high at t+1;
  - earliest res_valid at t+4 (Fin low sampled t+2, Fin high sampled t+3, registered t+4).
- Timeout:
  - The counter increments every cycle in WAIT_BUSY or WAIT_FIN.
  - When it reaches TIMEOUT, set err=1 (sticky until reset) and go to IDLE.
  - No result is produced; total and n_words are unchanged.
- Arithmetic: the sum is computed at TOT_W+1 bits, then clamped. There is no wrap-around.
- A Fin glitch high in WAIT_BUSY is ignored; only the low-then-high sequence completes a word.
- Cuenta is sampled only on the WAIT_FIN→OUT transition.
- Reset asserted in any state (including mid-WAIT or OUT with res_valid=1):
  - next edge returns all outputs to reset values;
  - the pending word and result are discarded;
  - Start is not pulsed.
- Simultaneous dato_valid and res_valid: the block cannot accept a new word until OUT completes. There is no overlap.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs → all outputs 0, Start never high. Release → dato_ready=1 on the next cycle.
- Single word: dato_in=3'b111, cuenta1 model drops Fin the cycle after Start, then raises Fin with Cuenta=4'd3 two cycles later, res_ready=1 → exactly one Start pulse, Q=3'b111, res_cuenta=3, total=3, n_words=1.
- Back-pressure: res_ready=0 for 5 cycles after res_valid → res_cuenta and res_valid held, dato_ready=0, total unchanged. res_ready=1 → total updates once.
- Timeout with TIMEOUT=64: Fin held at 1 permanently → err=1 after 64 wait cycles, back to IDLE with no res_valid. Then a normal word still completes with err remaining 1.
- Saturation with TOT_W=8: 100 words each returning Cuenta=3 → total=255 (not 44), n_words=100.
- Reset mid-operation: assert rst_n=0 while in WAIT_FIN → next cycle state=IDLE, res_valid=0, total keeps no partial update. A subsequent word behaves normally.
